// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and the magnitude helper.
package div_pkg;

    // Widest operand the magnitude helper can take; div_seq needs WIDTH < MAX_W.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Caller sign-extends the operand to MAX_W, so the most negative value comes
    // back as the unsigned magnitude 1 << (WIDTH-1) after truncation.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value, input logic sign);
        return (sign && value[MAX_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: try to subtract the aligned divisor from the partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rem_i,
    input  logic [2*WIDTH-1:0] dsh_i,
    output logic [2*WIDTH-1:0] rem_o,
    output logic               q_bit_o
);

    logic [2*WIDTH:0] diff;

    assign diff    = {1'b0, rem_i} - {1'b0, dsh_i};
    assign q_bit_o = ~diff[2*WIDTH];
    assign rem_o   = q_bit_o ? diff[2*WIDTH-1:0] : rem_i;

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, signed or unsigned per request, valid/ready on both sides.
//   state   | meaning
//   IDLE    | in_ready high, waiting for a request
//   BUSY    | one quotient bit per cycle, WIDTH cycles
//   DONE    | result and flags held until out_ready
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prem_q, prem_d;
    logic [2*WIDTH-1:0] dsh_q, dsh_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;

    logic [MAX_W-1:0]   dvd_ext, dvs_ext;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [2*WIDTH-1:0] step_rem;
    logic               step_bit;
    logic [WIDTH-1:0]   q_next;

    assign dvd_ext = {{(MAX_W-WIDTH){sign & dividend[WIDTH-1]}}, dividend};
    assign dvs_ext = {{(MAX_W-WIDTH){sign & divisor[WIDTH-1]}}, divisor};
    assign dvd_mag = WIDTH'(abs_mag(dvd_ext, sign));
    assign dvs_mag = WIDTH'(abs_mag(dvs_ext, sign));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (prem_q),
        .dsh_i   (dsh_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    assign q_next = {quot_q[WIDTH-2:0], step_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dsh_d   = dsh_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    negq_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr_d  = sign & dividend[WIDTH-1];
                    cnt_d   = CNT_W'(WIDTH);
                    prem_d  = {{WIDTH{1'b0}}, dvd_mag};
                    dsh_d   = {1'b0, dvs_mag, {(WIDTH-1){1'b0}}};
                    quot_d  = '0;
                    state_d = ST_BUSY;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (sign && dividend == MIN_VAL && divisor == '1) begin
                        quot_d  = dividend;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                prem_d = step_rem;
                dsh_d  = dsh_q >> 1;
                quot_d = q_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Sign fix-up folded into the last step so DONE sees final values.
                    quot_d  = negq_q ? -q_next : q_next;
                    rem_d   = negr_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dsh_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dsh_q   <= dsh_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed WIDTH=8 cases plus a WIDTH=32 random sweep against a behavioural model.
module tb_div_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8 = 1'b0, sg8 = 1'b0, or8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       ir8, ov8, dbz8, ovf8;
    logic [7:0] q8, r8;

    logic        iv32 = 1'b0, sg32 = 1'b0, or32 = 1'b0;
    logic [31:0] dvd32 = '0, dvs32 = '0;
    logic        ir32, ov32, dbz32, ovf32;
    logic [31:0] q32, r32;

    int checks = 0;
    int errors = 0;
    exp_t sb8[$];
    exp_t sb32[$];

    div_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .sign(sg8),
        .dividend(dvd8), .divisor(dvs8), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .overflow(ovf8)
    );

    div_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .sign(sg32),
        .dividend(dvd32), .divisor(dvs32), .out_valid(ov32), .out_ready(or32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32), .overflow(ovf32)
    );

    function automatic exp_t ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = 32'd0; e.ovf = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        e.lat = (e.dbz || e.ovf) ? 1 : 33;
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic dbz,
                                input logic ovf, input int lat);
        exp_t e;
        e.q = {24'd0, q}; e.r = {24'd0, r}; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
        return e;
    endfunction

    task automatic send8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (ir8 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (ir8 !== 1'b1) begin errors++; $display("FAIL send8_ready got %b want 1", ir8); end
        iv8 = 1'b1; sg8 = s; dvd8 = a; dvs8 = b;
        @(posedge clk);
        #1 iv8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    endtask

    task automatic recv8(input string name, input int stall);
        exp_t e;
        int lat = 1;
        @(negedge clk);
        while (ov8 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (sb8.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty", name); return;
        end
        e = sb8.pop_front();
        if (ov8 !== 1'b1) begin
            errors++; $display("FAIL %s timeout out_valid=%b want 1", name, ov8); return;
        end
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat); end
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (q8 !== e.q[7:0] || r8 !== e.r[7:0] || dbz8 !== e.dbz || ovf8 !== e.ovf ||
                ov8 !== 1'b1 || ir8 !== 1'b0) begin
                errors++;
                $display("FAIL %s result[%0d] got q=%h r=%h dbz=%b ovf=%b v=%b rdy=%b want q=%h r=%h dbz=%b ovf=%b v=1 rdy=0",
                         name, i, q8, r8, dbz8, ovf8, ov8, ir8, e.q[7:0], e.r[7:0], e.dbz, e.ovf);
            end
        end
        or8 = 1'b1;
        #1;
        checks++;
        if (ir8 !== 1'b0) begin errors++; $display("FAIL %s bubble in_ready got %b want 0", name, ir8); end
        @(posedge clk);
        #1 or8 = 1'b0;
        @(negedge clk);
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || dbz8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL %s release got v=%b rdy=%b dbz=%b ovf=%b want 0 1 0 0", name, ov8, ir8, dbz8, ovf8);
        end
    endtask

    task automatic issue8(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                          input exp_t e, input int stall);
        sb8.push_back(e);
        send8(s, a, b);
        recv8(name, stall);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || q8 !== 8'd0 || r8 !== 8'd0 || dbz8 !== 1'b0 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8 got rdy=%b v=%b q=%h r=%h dbz=%b ovf=%b want 1 0 00 00 0 0", ir8, ov8, q8, r8, dbz8, ovf8);
        end
        checks++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0 || q32 !== 32'd0 || r32 !== 32'd0) begin
            errors++;
            $display("FAIL reset32 got rdy=%b v=%b q=%h r=%h want 1 0 0 0", ir32, ov32, q32, r32);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        issue8("u200_7", 1'b0, 8'd200, 8'd7, mk(8'd28, 8'd4, 1'b0, 1'b0, 9), 0);
        issue8("u255_16", 1'b0, 8'd255, 8'd16, mk(8'd15, 8'd15, 1'b0, 1'b0, 9), 1);
        issue8("u5_9", 1'b0, 8'd5, 8'd9, mk(8'd0, 8'd5, 1'b0, 1'b0, 9), 0);
    endtask

    task automatic test_signed;
        issue8("s-100_7", 1'b1, 8'h9C, 8'h07, mk(8'hF2, 8'hFE, 1'b0, 1'b0, 9), 0);
        issue8("s100_-7", 1'b1, 8'h64, 8'hF9, mk(8'hF2, 8'h02, 1'b0, 1'b0, 9), 0);
        issue8("s-100_-7", 1'b1, 8'h9C, 8'hF9, mk(8'h0E, 8'hFE, 1'b0, 1'b0, 9), 0);
        issue8("s-128_3", 1'b1, 8'h80, 8'h03, mk(8'hD6, 8'hFE, 1'b0, 1'b0, 9), 0);
    endtask

    task automatic test_overflow;
        issue8("ovf_signed", 1'b1, 8'h80, 8'hFF, mk(8'h80, 8'h00, 1'b0, 1'b1, 1), 0);
        issue8("ovf_unsigned", 1'b0, 8'h80, 8'hFF, mk(8'h00, 8'h80, 1'b0, 1'b0, 9), 0);
    endtask

    task automatic test_div_zero;
        issue8("dbz_u37", 1'b0, 8'd37, 8'd0, mk(8'hFF, 8'd37, 1'b1, 1'b0, 1), 0);
        issue8("dbz_s-5", 1'b1, 8'hFB, 8'd0, mk(8'hFF, 8'hFB, 1'b1, 1'b0, 1), 2);
    endtask

    task automatic test_stall;
        issue8("stall5", 1'b0, 8'd200, 8'd7, mk(8'd28, 8'd4, 1'b0, 1'b0, 9), 5);
    endtask

    task automatic test_abort;
        send8(1'b0, 8'd200, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++; $display("FAIL abort got v=%b rdy=%b want 0 1", ov8, ir8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue8("after_abort_9_3", 1'b0, 8'd9, 8'd3, mk(8'd3, 8'd0, 1'b0, 1'b0, 9), 0);
    endtask

    task automatic test_random32;
        exp_t e;
        logic s;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            sb32.push_back(ref32(s, a, b));
            begin
                int t = 0;
                int lat = 1;
                int stall = $urandom_range(0, 3);
                while (ir32 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
                iv32 = 1'b1; sg32 = s; dvd32 = a; dvs32 = b;
                @(posedge clk);
                #1 iv32 = 1'b0; dvd32 = $urandom; dvs32 = $urandom;
                @(negedge clk);
                while (ov32 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
                e = sb32.pop_front();
                repeat (stall) @(negedge clk);
                checks++;
                if (ov32 !== 1'b1 || lat != e.lat || q32 !== e.q || r32 !== e.r ||
                    dbz32 !== e.dbz || ovf32 !== e.ovf) begin
                    errors++;
                    $display("FAIL rand32[%0d] s=%b a=%h b=%h got v=%b lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=%0d q=%h r=%h dbz=%b ovf=%b",
                             n, s, a, b, ov32, lat, q32, r32, dbz32, ovf32, e.lat, e.q, e.r, e.dbz, e.ovf);
                end
                or32 = 1'b1;
                @(posedge clk);
                #1 or32 = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_overflow;
        test_div_zero;
        test_stall;
        test_abort;
        test_random32;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
